brc_resolve: RTL and testbench

- Branch resolution unit in the EX stage; it consumes the branch comparator flags (less/equal) and drives the comparator's unsigned-select back from funct3.
- Decides the actual branch/jump outcome and compares it with the IF-stage prediction.
- On a mispredict, issues a registered one-cycle PC redirect to fetch, then holds a fixed-length flush of the younger pipeline stages.

---
 rtl/brc_resolve_if.sv | 38 +++
 rtl/brc_resolve.sv | 132 +++++++++++++
 tb/tb_brc_resolve.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/brc_resolve_if.sv
// ============================================================================
// Module      : brc_resolve_if
// Description : EX-stage branch resolution bus between pipeline and resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface brc_resolve_if;
    logic        i_valid;
    logic        i_stall;
    logic        i_is_branch;
    logic        i_is_jump;
    logic [2:0]  i_funct3;
    logic        i_brc_less;
    logic        i_brc_equal;
    logic        i_pred_taken;
    logic [31:0] i_pc;
    logic [31:0] i_target;
    logic        o_brc_un;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_flush;
    logic        o_illegal;

    modport master (
        output i_valid, i_stall, i_is_branch, i_is_jump, i_funct3,
               i_brc_less, i_brc_equal, i_pred_taken, i_pc, i_target,
        input  o_brc_un, o_redirect, o_redirect_pc, o_flush, o_illegal
    );

    modport slave (
        input  i_valid, i_stall, i_is_branch, i_is_jump, i_funct3,
               i_brc_less, i_brc_equal, i_pred_taken, i_pc, i_target,
        output o_brc_un, o_redirect, o_redirect_pc, o_flush, o_illegal
    );
endinterface

`default_nettype wire

// File: rtl/brc_resolve.sv
// ============================================================================
// Module      : brc_resolve
// Description : Branch resolution, mispredict redirect and fixed-length flush.
//               Optional statistics counters under BRC_RESOLVE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module brc_resolve #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    brc_resolve_if.slave     bus
`ifdef BRC_RESOLVE_STATS_EN
    ,
    output logic [31:0]      o_br_count,
    output logic [31:0]      o_mispred_count
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_flush;
    logic        r_illegal;

    logic        w_eval;
    logic        w_taken;
    logic        w_mis;
    logic        w_reserved;
    logic [31:0] w_corr_pc;

    assign bus.o_brc_un = bus.i_funct3[1] & bus.i_is_branch;

    always_comb begin
        w_taken    = 1'b0;
        w_reserved = 1'b0;
        if (bus.i_is_jump) begin
            w_taken = 1'b1;
        end else begin
            case (bus.i_funct3)
                3'b000:          w_taken = bus.i_brc_equal;
                3'b001:          w_taken = ~bus.i_brc_equal;
                3'b100, 3'b110:  w_taken = bus.i_brc_less;
                3'b101, 3'b111:  w_taken = ~bus.i_brc_less;
                default: begin
                    w_taken    = 1'b0;
                    w_reserved = bus.i_is_branch;
                end
            endcase
        end
    end

    assign w_eval    = bus.i_valid & ~bus.i_stall & (bus.i_is_branch | bus.i_is_jump)
                     & (r_state == S_IDLE);
    assign w_mis     = w_eval & (w_taken != bus.i_pred_taken);
    assign w_corr_pc = w_taken ? bus.i_target : (bus.i_pc + 32'd4);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_flush       <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            r_illegal  <= w_eval & w_reserved;
            case (r_state)
                S_IDLE: begin
                    if (w_mis) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= w_corr_pc;
                        r_flush       <= 1'b1;
                        r_cnt         <= c_CNT_LOAD;
                        r_state       <= S_FLUSH;
                    end else begin
                        r_flush <= 1'b0;
                    end
                end
                // Counter runs through stalls: younger stages are dead either way.
                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_flush <= 1'b1;
                    end
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_redirect    = r_redirect;
    assign bus.o_redirect_pc = r_redirect_pc;
    assign bus.o_flush       = r_flush;
    assign bus.o_illegal     = r_illegal;

`ifdef BRC_RESOLVE_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_br_count      <= 32'd0;
            o_mispred_count <= 32'd0;
        end else begin
            if (w_eval && (o_br_count != 32'hFFFF_FFFF)) begin
                o_br_count <= o_br_count + 32'd1;
            end
            if (w_mis && (o_mispred_count != 32'hFFFF_FFFF)) begin
                o_mispred_count <= o_mispred_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_brc_resolve.sv
// ============================================================================
// Module      : tb_brc_resolve
// Description : Self-checking scoreboard bench for brc_resolve.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brc_resolve;

    localparam int unsigned c_FLUSH = 2;

    logic i_clk;
    logic i_rst_n;

    brc_resolve_if bus ();

`ifdef BRC_RESOLVE_STATS_EN
    logic [31:0] w_br_count;
    logic [31:0] w_mis_count;
`endif

    brc_resolve #(.FLUSH_CYCLES(c_FLUSH)) u_dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .bus             (bus)
`ifdef BRC_RESOLVE_STATS_EN
        ,
        .o_br_count      (w_br_count),
        .o_mispred_count (w_mis_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        redir;
        logic [31:0] pc;
        logic        flush;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_left = 0;
    logic [31:0] m_rpc = 32'd0;
    int          m_br = 0;
    int          m_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ref_taken(input logic j, input logic [2:0] f3,
                                       input logic l, input logic e);
        if (j) return 1'b1;
        case (f3)
            3'b000: return e;
            3'b001: return ~e;
            3'b100: return l;
            3'b110: return l;
            3'b101: return ~l;
            3'b111: return ~l;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle at negedge and push what the next posedge must produce.
    task automatic drive(input logic v, input logic s, input logic b, input logic j,
                         input logic [2:0] f3, input logic l, input logic e,
                         input logic p, input logic [31:0] pc, input logic [31:0] tgt);
        logic ev, tk, mis, ill;
        exp_t x;
        @(negedge i_clk);
        bus.i_valid = v; bus.i_stall = s; bus.i_is_branch = b; bus.i_is_jump = j;
        bus.i_funct3 = f3; bus.i_brc_less = l; bus.i_brc_equal = e;
        bus.i_pred_taken = p; bus.i_pc = pc; bus.i_target = tgt;
        ev  = v & ~s & (b | j) & (m_left == 0);
        tk  = ref_taken(j, f3, l, e);
        mis = ev & (tk != p);
        ill = ev & b & ~j & (f3[2:1] == 2'b01);
        if (ev)  m_br++;
        if (mis) m_mis++;
        if (m_left > 0) begin
            m_left--;
        end else if (mis) begin
            m_left = c_FLUSH;
            m_rpc  = tk ? tgt : pc + 32'd4;
        end
        x.redir = mis; x.pc = m_rpc; x.flush = (m_left != 0); x.ill = ill;
        sb.push_back(x);
        #1 chk("brc_un", {31'd0, bus.o_brc_un}, {31'd0, f3[1] & b});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom), 1'($urandom), 1'($urandom),
                  1'b0, 32'h0, 32'h0);
    endtask

    initial begin : mon
        exp_t x;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("redirect",    {31'd0, bus.o_redirect}, {31'd0, x.redir});
                chk("redirect_pc", bus.o_redirect_pc, x.pc);
                chk("flush",       {31'd0, bus.o_flush}, {31'd0, x.flush});
                chk("illegal",     {31'd0, bus.o_illegal}, {31'd0, x.ill});
            end
        end
    end

    initial begin : stim
        logic [2:0] f3;
        logic       b;
        i_rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_stall = 1'b0; bus.i_is_branch = 1'b0;
        bus.i_is_jump = 1'b0; bus.i_funct3 = 3'd0; bus.i_brc_less = 1'b0;
        bus.i_brc_equal = 1'b0; bus.i_pred_taken = 1'b0; bus.i_pc = 32'd0;
        bus.i_target = 32'd0;

        // Reset held with random inputs
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            f3 = 3'($urandom); b = 1'($urandom);
            bus.i_valid = 1'($urandom); bus.i_is_branch = b; bus.i_is_jump = 1'($urandom);
            bus.i_funct3 = f3; bus.i_brc_less = 1'($urandom); bus.i_brc_equal = 1'($urandom);
            bus.i_pred_taken = 1'($urandom); bus.i_pc = $urandom; bus.i_target = $urandom;
            #1;
            chk("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
            chk("rst_pc",       bus.o_redirect_pc, 32'd0);
            chk("rst_flush",    {31'd0, bus.o_flush}, 32'd0);
            chk("rst_illegal",  {31'd0, bus.o_illegal}, 32'd0);
            chk("rst_brc_un",   {31'd0, bus.o_brc_un}, {31'd0, f3[1] & b});
        end
        bus.i_valid = 1'b0;
        i_rst_n = 1'b1;
        idle(2);

        // BEQ taken, predicted not-taken
        drive(1, 0, 1, 0, 3'b000, 0, 1, 0, 32'h100, 32'h200);
        idle(3);
        // BGEU not taken, predicted taken, fall-through wraps
        drive(1, 0, 1, 0, 3'b111, 1, 0, 1, 32'hFFFF_FFFC, 32'h300);
        idle(3);
        // Second mispredict while flushing is ignored
        drive(1, 0, 1, 0, 3'b001, 0, 0, 0, 32'h380, 32'h400);
        drive(1, 0, 0, 1, 3'b000, 0, 0, 0, 32'h384, 32'h500);
        idle(3);
        // Stalled mispredict resolves only after stall drops
        for (int k = 0; k < 3; k++)
            drive(1, 1, 1, 0, 3'b100, 1, 0, 0, 32'h600, 32'h700);
        drive(1, 0, 1, 0, 3'b100, 1, 0, 0, 32'h600, 32'h700);
        idle(3);
        // Reserved funct3: correct not-taken, then mispredicted taken
        drive(1, 0, 1, 0, 3'b010, 1, 1, 0, 32'h800, 32'h900);
        idle(1);
        drive(1, 0, 1, 0, 3'b011, 0, 1, 1, 32'h810, 32'h910);
        idle(3);
        // Correct predictions, jump wins over branch
        drive(1, 0, 1, 0, 3'b100, 1, 0, 1, 32'hA00, 32'hB00);
        drive(1, 0, 0, 1, 3'b000, 0, 0, 1, 32'hA04, 32'hC00);
        drive(1, 0, 1, 1, 3'b000, 0, 0, 1, 32'hA08, 32'hD00);
        drive(1, 0, 1, 0, 3'b101, 1, 0, 0, 32'hA0C, 32'hE00);
        idle(1);
        // Random traffic
        for (int k = 0; k < 60; k++)
            drive(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
        idle(4);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge i_clk);
        chk("sb_drain", sb.size(), 32'd0);
        @(negedge i_clk);

`ifdef BRC_RESOLVE_STATS_EN
        chk("br_count",  w_br_count,  m_br);
        chk("mis_count", w_mis_count, m_mis);
`endif

        // Asynchronous reset in the middle of a flush
        drive(1, 0, 1, 0, 3'b000, 0, 1, 0, 32'hF00, 32'hF80);
        @(posedge i_clk);
        #2;
        chk("pre_rst_flush", {31'd0, bus.o_flush}, 32'd1);
        chk("pre_rst_redir", {31'd0, bus.o_redirect}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("async_flush", {31'd0, bus.o_flush}, 32'd0);
        chk("async_redir", {31'd0, bus.o_redirect}, 32'd0);
        chk("async_pc",    bus.o_redirect_pc, 32'd0);
`ifdef BRC_RESOLVE_STATS_EN
        chk("async_br_count", w_br_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
